fpga_mem_arbiter: RTL and testbench
===================================

Name: fpga_mem_arbiter

Overview:
Two-master to one-slave Avalon-MM arbiter for the FPGA-side memory port.
- Master 0 is the HPS fpga_mem bridge; master 1 is the local POWERLINK DMA.
- The slave is the shared on-chip/packet-buffer memory.
- Arbitration is round-robin with zero added command latency. Pipelined reads are allowed, and responses are routed back to the issuing master through an in-order read-tag FIFO.

Parameters:
ADDR_W, 27, word-address width of all three interfaces
DATA_W, 32, data width; byteenable width = DATA_W/8
MAX_OUTST, 4, max outstanding reads (tag FIFO depth, power of two, >=2)

Ports:
clk100_clk  in  1  single clock
reset_clk100_reset_n  in  1  asynchronous, active-low reset
m0_address / m1_address  in  ADDR_W  master command address
m0_read / m1_read  in  1  read request
m0_write / m1_write  in  1  write request
m0_writedata / m1_writedata  in  DATA_W  write data
m0_byteenable / m1_byteenable  in  DATA_W/8  byte enables
m0_waitrequest / m1_waitrequest  out  1  command stall to master
m0_readdata / m1_readdata  out  DATA_W  read data (= s_readdata)
m0_readdatavalid / m1_readdatavalid  out  1  response strobe to master
s_address  out  ADDR_W  slave address
s_read  out  1  slave read
s_write  out  1  slave write
s_writedata  out  DATA_W  slave write data
s_byteenable  out  DATA_W/8  slave byte enables
s_waitrequest  in  1  slave stall
s_readdata  in  DATA_W  slave read data
s_readdatavalid  in  1  slave response strobe
rsp_err  out  1  sticky: readdatavalid received with tag FIFO empty

Behaviour:
Reset state:
- FSM = UNLOCKED, last = 1 (master 0 wins first tie), tag FIFO empty, rsp_err = 0.
- While reset is asserted: s_read/s_write = 0, both m*_waitrequest = 1, both m*_readdatavalid = 0.

Request qualification:
- req_i = m_i_write | (m_i_read & !fifo_full).
- m_i_read and m_i_write both high is illegal; treat it as a read.

Grant selection (combinational, zero latency):
- LOCKEDx: grant = x.
- UNLOCKED with one request: grant = the requester.
- UNLOCKED with both requesting: grant = !last.
- No request: s_read/s_write = 0.

Slave command and master stall:
- The slave command is a mux of the granted master's qualified command.
- Granted master: m_waitrequest = s_waitrequest.
- Ungranted master: m_waitrequest = 1.
- A master whose read is blocked by fifo_full sees waitrequest = 1.

FSM:
- UNLOCKED -> LOCKEDx when the command from grant x is driven and s_waitrequest = 1. This holds the slave command stable per Avalon.
- LOCKEDx -> UNLOCKED on accept (command & !s_waitrequest).
- A LOCKEDx read is never dropped by fifo_full: no push occurs while locked.

On accept:
- last <= grant.
- If read: push grant ID into the tag FIFO.

Responses:
- s_readdatavalid pops the FIFO head.
- Route to m[head]_readdatavalid; the other master's readdatavalid = 0.
- readdata goes to both masters unmuxed.
- If the FIFO is empty: no pop, no strobe, and rsp_err <= 1 (sticky until reset).

FIFO:
- count 0..MAX_OUTST; fifo_full = (count == MAX_OUTST).
- Push and pop in the same cycle keeps count.
- fifo_full is evaluated on the registered count. A same-cycle pop does not unblock a read.
- Pointers wrap modulo MAX_OUTST.

Writes:
- Posted and never tagged.
- Allowed while the FIFO is full.

Back-to-back transfers:
- Consecutive accepts on consecutive cycles are allowed, giving full throughput.
- Both masters continuously requesting alternate 0,1,0,1.

Reset mid-operation:
- Outstanding tags are discarded.
- Later slave responses hit an empty FIFO and set rsp_err. This is acceptable; the system resets the slave together with this block.

Decomposition:
Shared package:
- typedef master ID (1 bit)
- constants MST_HPS = 0, MST_DMA = 1
- FIFO count width = $clog2(MAX_OUTST) + 1

Sub-module fpga_mem_arb_tagfifo:
- Parameterised depth, 1-bit data.
- Ports: push, pop, din, dout, count, full, empty.
- Async active-low reset.

Test Plan:
- Single master: m0 writes 0x0000010 <= 0xDEADBEEF, then reads it -> s_write and s_read each for 1 cycle, m0_readdatavalid with 0xDEADBEEF, m1 waitrequest held 1.
- Contention: m0 and m1 both read continuously for 8 cycles with slave waitrequest = 0 and read latency 2 -> grants alternate 0,1,0,1..., and each readdatavalid is routed to the issuer in order.
- Slave stall: m1 write while s_waitrequest = 1 for 3 cycles, m0 read raised during the stall -> s_address/s_writedata stay stable, m0 waitrequest = 1 until after m1's accept, then m0 is granted.
- FIFO full: MAX_OUTST = 4, slave latency 20, m0 issues 6 reads -> 4 accepted and the 5th stalled. Meanwhile an m1 write is accepted. After the first response the 5th read is accepted on the next cycle.
- Spurious response: s_readdatavalid pulse with no outstanding read -> no m*_readdatavalid, rsp_err = 1 and remains 1 until reset.
- Mid-op reset: 3 reads outstanding, assert reset for 2 cycles -> waitrequests = 1, count = 0, rsp_err = 0. After release the first grant goes to m0 on a tie.

Source files
------------

// File: rtl/fpga_mem_arbiter_pkg.sv
// Shared types and constants for the two-master FPGA memory-port arbiter.
package fpga_mem_arbiter_pkg;

  typedef logic mst_id_t;

  localparam mst_id_t MST_HPS = 1'b0;
  localparam mst_id_t MST_DMA = 1'b1;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKED0  = 2'd1,
    ST_LOCKED1  = 2'd2
  } arb_state_t;

  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fpga_mem_arb_tagfifo.sv
// In-order read-tag FIFO: remembers which master issued each outstanding read.
module fpga_mem_arb_tagfifo
  import fpga_mem_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   din,
  output logic                   dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0] mem;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Pointers are PTR_W bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fpga_mem_arbiter.sv
// Round-robin two-master to one-slave Avalon-MM arbiter with zero command
// latency and in-order routing of pipelined read responses.
module fpga_mem_arbiter
  import fpga_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 27,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic                clk100_clk,
  input  logic                reset_clk100_reset_n,

  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,

  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,

  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata,
  input  logic                s_readdatavalid,

  output logic                rsp_err
);

  localparam int CNT_W = fifo_cnt_w(MAX_OUTST);

  arb_state_t       state;
  arb_state_t       state_nxt;
  mst_id_t          last;
  mst_id_t          grant;
  mst_id_t          fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             locked;
  logic             rd0, wr0, req0;
  logic             rd1, wr1, req1;
  logic             cmd_rd, cmd_wr, cmd_vld;
  logic             accept;
  logic             tag_push, tag_pop;

  // Read+write together is illegal on Avalon; the read wins.
  assign rd0    = m0_read;
  assign wr0    = m0_write & ~m0_read;
  assign rd1    = m1_read;
  assign wr1    = m1_write & ~m1_read;
  assign req0   = wr0 | (rd0 & ~fifo_full);
  assign req1   = wr1 | (rd1 & ~fifo_full);
  assign locked = (state != ST_UNLOCKED);

  always_ff @(posedge clk100_clk or negedge reset_clk100_reset_n) begin
    if (!reset_clk100_reset_n) state <= ST_UNLOCKED;
    else                       state <= state_nxt;
  end

  // A stalled command pins the grant so the slave sees it held stable.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_UNLOCKED: begin
        if (cmd_vld && s_waitrequest)
          state_nxt = (grant == MST_DMA) ? ST_LOCKED1 : ST_LOCKED0;
      end
      ST_LOCKED0, ST_LOCKED1: begin
        if (accept || !cmd_vld) state_nxt = ST_UNLOCKED;
      end
      default: state_nxt = ST_UNLOCKED;
    endcase
  end

  // A locked read was qualified when first presented, and no other push can
  // happen while locked, so it bypasses the full check.
  always_comb begin
    grant  = ~last;
    cmd_rd = 1'b0;
    cmd_wr = 1'b0;
    case (state)
      ST_LOCKED0: grant = MST_HPS;
      ST_LOCKED1: grant = MST_DMA;
      default: begin
        if (req0 && !req1)      grant = MST_HPS;
        else if (req1 && !req0) grant = MST_DMA;
      end
    endcase
    if (reset_clk100_reset_n) begin
      if (grant == MST_DMA) begin
        cmd_rd = rd1 & (locked | ~fifo_full);
        cmd_wr = wr1;
      end else begin
        cmd_rd = rd0 & (locked | ~fifo_full);
        cmd_wr = wr0;
      end
    end
  end

  assign cmd_vld = cmd_rd | cmd_wr;
  assign accept  = cmd_vld & ~s_waitrequest;

  assign s_read       = cmd_rd;
  assign s_write      = cmd_wr;
  assign s_address    = (grant == MST_DMA) ? m1_address    : m0_address;
  assign s_writedata  = (grant == MST_DMA) ? m1_writedata  : m0_writedata;
  assign s_byteenable = (grant == MST_DMA) ? m1_byteenable : m0_byteenable;

  assign m0_waitrequest = ~(accept & (grant == MST_HPS));
  assign m1_waitrequest = ~(accept & (grant == MST_DMA));

  assign tag_push = accept & cmd_rd;
  assign tag_pop  = s_readdatavalid & ~fifo_empty;

  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign m0_readdatavalid = tag_pop & (fifo_head == MST_HPS);
  assign m1_readdatavalid = tag_pop & (fifo_head == MST_DMA);

  always_ff @(posedge clk100_clk or negedge reset_clk100_reset_n) begin
    if (!reset_clk100_reset_n) begin
      last    <= MST_DMA;
      rsp_err <= 1'b0;
    end else begin
      if (accept) last <= grant;
      if (s_readdatavalid && (fifo_count == '0)) rsp_err <= 1'b1;
    end
  end

  fpga_mem_arb_tagfifo #(
    .DEPTH (MAX_OUTST)
  ) u_tagfifo (
    .clk   (clk100_clk),
    .rst_n (reset_clk100_reset_n),
    .push  (tag_push),
    .pop   (tag_pop),
    .din   (grant),
    .dout  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_fpga_mem_arbiter.sv
// Randomized and directed bench for fpga_mem_arbiter against a queue-based model.
module tb_fpga_mem_arbiter;

  localparam int ADDR_W    = 27;
  localparam int DATA_W    = 32;
  localparam int BE_W      = DATA_W / 8;
  localparam int MAX_OUTST = 4;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] m0_address, m1_address, s_address;
  logic              m0_read, m0_write, m1_read, m1_write;
  logic [DATA_W-1:0] m0_writedata, m1_writedata, s_writedata;
  logic [BE_W-1:0]   m0_byteenable, m1_byteenable, s_byteenable;
  logic              m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0] m0_readdata, m1_readdata, s_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic              s_read, s_write, s_waitrequest, s_readdatavalid;
  logic              rsp_err;

  fpga_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTST(MAX_OUTST)) dut (
    .clk100_clk           (clk),
    .reset_clk100_reset_n (rst_n),
    .m0_address           (m0_address),
    .m0_read              (m0_read),
    .m0_write             (m0_write),
    .m0_writedata         (m0_writedata),
    .m0_byteenable        (m0_byteenable),
    .m0_waitrequest       (m0_waitrequest),
    .m0_readdata          (m0_readdata),
    .m0_readdatavalid     (m0_readdatavalid),
    .m1_address           (m1_address),
    .m1_read              (m1_read),
    .m1_write             (m1_write),
    .m1_writedata         (m1_writedata),
    .m1_byteenable        (m1_byteenable),
    .m1_waitrequest       (m1_waitrequest),
    .m1_readdata          (m1_readdata),
    .m1_readdatavalid     (m1_readdatavalid),
    .s_address            (s_address),
    .s_read               (s_read),
    .s_write              (s_write),
    .s_writedata          (s_writedata),
    .s_byteenable         (s_byteenable),
    .s_waitrequest        (s_waitrequest),
    .s_readdata           (s_readdata),
    .s_readdatavalid      (s_readdatavalid),
    .rsp_err              (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: who holds the slave, who won last, outstanding read tags.
  int md_lock = -1;
  int md_last = 1;
  int md_q[$];
  bit md_err  = 0;
  bit m_acc, m_push, m_cmd;
  int m_g;

  // Slave responder and master BFM state.
  bit slv_auto = 0;
  bit slv_fire = 0;
  int slv_prob = 100;
  int slv_lat_min = 2;
  int slv_lat_max = 2;
  int slv_due[$];
  bit                pend[2];
  bit                prd[2];
  bit                pwr[2];
  logic [ADDR_W-1:0] paddr[2];
  logic [DATA_W-1:0] pdata[2];
  logic [BE_W-1:0]   pbe[2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_cycle();
    bit full, r0, r1, w0, w1, q0, q1, crd, cwr, acc;
    int g;
    #1;
    m_acc = 0; m_push = 0; m_cmd = 0; m_g = -1;
    if (!rst_n) begin
      chk("rst_s_read", s_read, 0);
      chk("rst_s_write", s_write, 0);
      chk("rst_m0_waitrequest", m0_waitrequest, 1);
      chk("rst_m1_waitrequest", m1_waitrequest, 1);
      chk("rst_m0_readdatavalid", m0_readdatavalid, 0);
      chk("rst_m1_readdatavalid", m1_readdatavalid, 0);
      chk("rst_rsp_err", rsp_err, 0);
      return;
    end
    full = (md_q.size() == MAX_OUTST);
    r0 = m0_read; w0 = m0_write && !m0_read;
    r1 = m1_read; w1 = m1_write && !m1_read;
    g = -1;
    if (md_lock >= 0) g = md_lock;
    else begin
      q0 = w0 || (r0 && !full);
      q1 = w1 || (r1 && !full);
      if (q0 && q1) g = 1 - md_last;
      else if (q0)  g = 0;
      else if (q1)  g = 1;
    end
    crd = 0; cwr = 0;
    if (g == 0) begin crd = r0 && (md_lock >= 0 || !full); cwr = w0; end
    if (g == 1) begin crd = r1 && (md_lock >= 0 || !full); cwr = w1; end
    acc = (crd || cwr) && !s_waitrequest;
    chk("s_read", s_read, crd);
    chk("s_write", s_write, cwr);
    if (crd || cwr) begin
      chk("s_address", s_address, (g == 1) ? m1_address : m0_address);
      chk("s_writedata", s_writedata, (g == 1) ? m1_writedata : m0_writedata);
      chk("s_byteenable", s_byteenable, (g == 1) ? m1_byteenable : m0_byteenable);
    end
    chk("m0_waitrequest", m0_waitrequest, !(acc && g == 0));
    chk("m1_waitrequest", m1_waitrequest, !(acc && g == 1));
    chk("m0_readdatavalid", m0_readdatavalid, s_readdatavalid && md_q.size() > 0 && md_q[0] == 0);
    chk("m1_readdatavalid", m1_readdatavalid, s_readdatavalid && md_q.size() > 0 && md_q[0] == 1);
    chk("m0_readdata", m0_readdata, s_readdata);
    chk("m1_readdata", m1_readdata, s_readdata);
    chk("rsp_err", rsp_err, md_err);
    m_acc = acc; m_g = g; m_push = acc && crd; m_cmd = crd || cwr;
  endtask

  task automatic update_model();
    int tmp;
    if (!rst_n) begin
      md_lock = -1; md_last = 1; md_q.delete(); md_err = 0;
      return;
    end
    if (s_readdatavalid) begin
      if (md_q.size() > 0) tmp = md_q.pop_front();
      else md_err = 1;
    end
    if (m_acc) begin
      md_last = m_g;
      if (m_push) md_q.push_back(m_g);
      md_lock = -1;
    end else if (m_cmd && s_waitrequest) md_lock = m_g;
    else if (!m_cmd) md_lock = -1;
  endtask

  task automatic tick();
    int tmp;
    update_model();
    if (slv_fire) tmp = slv_due.pop_front();
    slv_fire = 0;
    if (slv_auto && m_push) slv_due.push_back(cyc + $urandom_range(slv_lat_max, slv_lat_min));
    @(negedge clk);
    cyc++;
  endtask

  task automatic drive_slave(input bit allow_spurious);
    slv_fire = 0;
    s_readdata = $urandom;
    if (slv_due.size() > 0 && slv_due[0] <= cyc && $urandom_range(99) < slv_prob) slv_fire = 1;
    s_readdatavalid = slv_fire;
    if (allow_spurious && slv_due.size() == 0 && $urandom_range(999) < 3) s_readdatavalid = 1;
  endtask

  task automatic idle_masters();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
  endtask

  initial begin
    rst_n = 0;
    idle_masters();
    m0_address = '0; m1_address = '0; m0_writedata = '0; m1_writedata = '0;
    m0_byteenable = '1; m1_byteenable = '1;
    s_waitrequest = 0; s_readdata = '0; s_readdatavalid = 0;
    for (int i = 0; i < 2; i++) pend[i] = 0;

    // Reset, with m0 already requesting.
    m0_read = 1;
    repeat (2) begin check_cycle(); tick(); end
    m0_read = 0;
    rst_n = 1;
    check_cycle(); tick();

    // Single master write then read.
    m0_write = 1; m0_address = 27'h0000010; m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'hF;
    check_cycle();
    chk("lit_wr_s_write", s_write, 1);
    chk("lit_wr_s_address", s_address, 27'h0000010);
    chk("lit_wr_s_writedata", s_writedata, 32'hDEADBEEF);
    chk("lit_wr_m1_wait", m1_waitrequest, 1);
    tick();
    m0_write = 0; m0_read = 1;
    check_cycle();
    chk("lit_rd_s_read", s_read, 1);
    chk("lit_rd_m0_wait", m0_waitrequest, 0);
    tick();
    m0_read = 0; s_readdatavalid = 1; s_readdata = 32'hDEADBEEF;
    check_cycle();
    chk("lit_rd_m0_rdv", m0_readdatavalid, 1);
    chk("lit_rd_m0_data", m0_readdata, 32'hDEADBEEF);
    chk("lit_rd_m1_rdv", m1_readdatavalid, 0);
    tick();
    s_readdatavalid = 0;

    // Contention: both masters read continuously, slave latency 2.
    slv_auto = 1; slv_prob = 100; slv_lat_min = 2; slv_lat_max = 2;
    for (int k = 0; k < 10; k++) begin
      m0_read = (k < 8); m1_read = (k < 8);
      m0_address = 27'h100 + 27'(k); m1_address = 27'h200 + 27'(k);
      drive_slave(0);
      check_cycle();
      if (k < 8) begin
        chk("lit_rr_m1_wait", m1_waitrequest, (k % 2) == 1);
        chk("lit_rr_m0_wait", m0_waitrequest, (k % 2) == 0);
      end
      if (k >= 2) begin
        chk("lit_rr_m1_rdv", m1_readdatavalid, (k % 2) == 0);
        chk("lit_rr_m0_rdv", m0_readdatavalid, (k % 2) == 1);
      end
      tick();
    end
    slv_auto = 0; s_readdatavalid = 0; idle_masters();

    // Slave stall on an m1 write, m0 read raised meanwhile.
    m1_write = 1; m1_address = 27'h0000123; m1_writedata = 32'hCAFEF00D; m1_byteenable = 4'h3;
    m0_address = 27'h0000456;
    s_waitrequest = 1;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) m0_read = 1;
      check_cycle();
      chk("lit_st_s_address", s_address, 27'h0000123);
      chk("lit_st_s_writedata", s_writedata, 32'hCAFEF00D);
      chk("lit_st_s_read", s_read, 0);
      chk("lit_st_m0_wait", m0_waitrequest, 1);
      tick();
    end
    s_waitrequest = 0;
    check_cycle();
    chk("lit_st_m1_accept", m1_waitrequest, 0);
    chk("lit_st_m0_wait_acc", m0_waitrequest, 1);
    tick();
    m1_write = 0;
    check_cycle();
    chk("lit_st_m0_grant", m0_waitrequest, 0);
    chk("lit_st_m0_addr", s_address, 27'h0000456);
    tick();
    m0_read = 0; s_readdatavalid = 1;
    check_cycle();
    chk("lit_st_m0_rdv", m0_readdatavalid, 1);
    tick();
    s_readdatavalid = 0;

    // FIFO full: m0 issues 6 reads, m1 writes while m0 is blocked.
    m0_read = 1;
    for (int k = 0; k < 4; k++) begin
      check_cycle(); chk("lit_ff_m0_acc", m0_waitrequest, 0); tick();
    end
    m1_write = 1;
    check_cycle();
    chk("lit_ff_m0_blocked", m0_waitrequest, 1);
    chk("lit_ff_s_read", s_read, 0);
    chk("lit_ff_m1_wr_acc", m1_waitrequest, 0);
    tick();
    m1_write = 0; s_readdatavalid = 1;
    check_cycle();
    chk("lit_ff_pop_rdv", m0_readdatavalid, 1);
    chk("lit_ff_pop_still_wait", m0_waitrequest, 1);
    tick();
    s_readdatavalid = 0;
    check_cycle(); chk("lit_ff_5th_acc", m0_waitrequest, 0); tick();
    check_cycle(); chk("lit_ff_6th_wait", m0_waitrequest, 1); tick();
    s_readdatavalid = 1; check_cycle(); tick(); s_readdatavalid = 0;
    check_cycle(); chk("lit_ff_6th_acc", m0_waitrequest, 0); tick();
    m0_read = 0;
    s_readdatavalid = 1;
    repeat (4) begin check_cycle(); tick(); end
    s_readdatavalid = 0;

    // Spurious response with nothing outstanding.
    s_readdatavalid = 1;
    check_cycle();
    chk("lit_sp_m0_rdv", m0_readdatavalid, 0);
    chk("lit_sp_m1_rdv", m1_readdatavalid, 0);
    tick();
    s_readdatavalid = 0;
    repeat (3) begin check_cycle(); chk("lit_sp_err_sticky", rsp_err, 1); tick(); end

    // Mid-operation reset with 3 reads outstanding.
    m0_read = 1;
    repeat (3) begin check_cycle(); tick(); end
    rst_n = 0;
    repeat (2) begin
      check_cycle();
      chk("lit_mr_m0_wait", m0_waitrequest, 1);
      chk("lit_mr_m1_wait", m1_waitrequest, 1);
      chk("lit_mr_err", rsp_err, 0);
      tick();
    end
    rst_n = 1; m1_read = 1;
    check_cycle();
    chk("lit_mr_tie_m0", m0_waitrequest, 0);
    chk("lit_mr_tie_m1", m1_waitrequest, 1);
    tick();
    m0_read = 0;
    check_cycle(); chk("lit_mr_m1_next", m1_waitrequest, 0); tick();
    m1_read = 0; s_readdatavalid = 1;
    check_cycle(); chk("lit_mr_rdv0", m0_readdatavalid, 1); tick();
    check_cycle(); chk("lit_mr_rdv1", m1_readdatavalid, 1); tick();
    s_readdatavalid = 0;

    // Randomized traffic with random stalls, latencies and occasional resets.
    slv_auto = 1; slv_prob = 70; slv_lat_min = 1; slv_lat_max = 6;
    for (int n = 0; n < 4000; n++) begin
      rst_n = ($urandom_range(999) >= 2);
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(99) < 55) begin
          int kk;
          kk = $urandom_range(99);
          pend[i]  = 1;
          prd[i]   = (kk < 48) || (kk >= 90);
          pwr[i]   = (kk >= 48);
          paddr[i] = ADDR_W'($urandom);
          pdata[i] = $urandom;
          pbe[i]   = BE_W'($urandom);
        end
      end
      m0_read = pend[0] && prd[0]; m0_write = pend[0] && pwr[0];
      m0_address = paddr[0]; m0_writedata = pdata[0]; m0_byteenable = pbe[0];
      m1_read = pend[1] && prd[1]; m1_write = pend[1] && pwr[1];
      m1_address = paddr[1]; m1_writedata = pdata[1]; m1_byteenable = pbe[1];
      s_waitrequest = ($urandom_range(99) < 30);
      drive_slave(1);
      check_cycle();
      for (int i = 0; i < 2; i++) if (pend[i] && m_acc && m_g == i) pend[i] = 0;
      tick();
    end

    rst_n = 1; idle_masters(); slv_auto = 0; s_readdatavalid = 0; s_waitrequest = 0;
    check_cycle(); tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
